multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle RV32I control FSM for the next-generation core: sequences each instruction over 3–5 cycles around a shared memory port, an instruction register and ALUOut/Data registers in the datapath. It implements the full branch set (beq/bne/blt/bge/bltu/bgeu) from ALU flags, handles a ready-based memory handshake with a timeout, and traps illegal encodings into a sticky fault state. The block sits between the instruction register and the multi-cycle datapath, replacing single-cycle decode.

## Interface
- MEM_TIMEOUT, 16: maximum cycles waiting for `mem_ready`; 0 disables the timeout.
- ALUCTRL_W, 4: width of `alu_control`; must be ≥4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- op  in  7  opcode from the instruction register.
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- zero, neg, carry, ovf  in  1 each  ALU flags from the current cycle; `carry` = 1 means no borrow on subtract.
- mem_ready  in  1  memory completes the current access this cycle.
- md_done  in  1  mul/div unit result valid (used only with MULDIV_EN).
- mem_req, mem_write, ir_write, pc_write, reg_write  out  1 each  strobes.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from `op` in every state.
- alu_control  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- md_start  out  1; md_op  out  3  mul/div start pulse and funct3.
- illegal, bus_err  out  1 each  sticky fault causes.

## Operation
- While `rst_n`=0, all outputs are 0; on the first cycle after release, the state is FETCH. Outputs are Moore-decoded from the state, `op`/`funct*` and flags. Unlisted strobes are 0, and `alu_control` = add unless stated.
- FETCH: mem_req, adr_src=0, a=00, b=10, result_src=10. ir_write and pc_write = mem_ready. On ready → DECODE, else hold.
- DECODE: a=01, b=01 (branch/JAL target into ALUOut). Dispatch by `op`:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR1
  - 0110111 → LUI
  - any other opcode → FAULT with illegal=1.
- MEMADR: a=10, b=01. → MEMWRITE if op[5], else MEMREAD.
- MEMREAD: mem_req, adr_src=1. On ready → MEMWB. MEMWB: result_src=01, reg_write → FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1. On ready → FETCH.
- EXECR: a=10, b=00, ALU op from funct3/funct7[5]; sub only when funct7[5]. EXECI: a=10, b=01, same decode; funct7[5] is honoured only for funct3=101 (srai). Both → ALUWB.
- ALUWB: result_src=00, reg_write → FETCH.
- BRANCH: a=10, b=00, sub, result_src=00, pc_write=take → FETCH. The branch is taken per funct3:
  - 000: zero
  - 001: !zero
  - 100: neg^ovf
  - 101: !(neg^ovf)
  - 110: !carry
  - 111: carry
  - 010/011 → FAULT with illegal=1.
- JAL: a=01, b=10, result_src=00, pc_write → ALUWB (rd ← OldPC+4).
- JALR1: a=10, b=01, result_src=10, pc_write → JALR2. JALR2: a=01, b=10, result_src=10, reg_write → FETCH. rs1==rd is safe because the PC is written first.
- LUI: a=11, b=01 → ALUWB.
- FAULT: all strobes 0; illegal/bus_err hold their values; only reset exits.
- Timeout: the wait counter clears on entry to FETCH/MEMREAD/MEMWRITE and increments each cycle with mem_req & !mem_ready. When it reaches MEM_TIMEOUT → FAULT with bus_err=1. mem_ready in the same cycle as the limit wins, and the access completes.

## Timing
- CPI: load 5, store 4, R/I/LUI/JAL/JALR 4, branch 3, each plus memory wait cycles.
- Zero-wait memory: FETCH is one cycle.
- Reset asserted mid-instruction aborts at the next edge; no strobe fires in the reset cycle.
- The counter width is $clog2(MEM_TIMEOUT+1); it saturates and never wraps.

## Configuration
- `RV_MULDIV_EN` defined: op 0110011 with funct7=0000001 → MULDIV state. md_start pulses for exactly the entry cycle, and md_op=funct3. The FSM holds until md_done → ALUWB with result_src=00. No timeout applies.
- `RV_MULDIV_EN` undefined: that encoding → FAULT with illegal=1; md_start and md_op are tied to 0.

## Test plan
- add x3,x1,x2 with mem_ready=1 → FETCH, DECODE, EXECR, ALUWB. reg_write pulses once in cycle 4; alu_control=0.
- lw, with mem_ready low 3 cycles in MEMREAD → 8 cycles total; adr_src=1 throughout MEMREAD; reg_write with result_src=01.
- bltu with carry=0, then bgeu with carry=0 → pc_write=1, then pc_write=0, in the BRANCH cycle; funct3=010 → illegal=1, and the FSM stays in FAULT.
- MEM_TIMEOUT=4 with mem_ready stuck low in FETCH → bus_err=1 after 4 wait cycles; mem_req=0 thereafter until rst_n pulse.
- Opcode 0000000 → illegal=1 one cycle after DECODE. rst_n low for one cycle → all outputs 0, and the next cycle is FETCH with mem_req=1.
- With RV_MULDIV_EN, mul with md_done after 5 cycles → single md_start pulse, then ALUWB. Without the macro → illegal=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM with memory timeout and sticky faults.
// Define RV_MULDIV_EN to route the M-extension encoding to an external mul/div unit.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic                 zero_i,
    input  logic                 neg_i,
    input  logic                 carry_i,
    input  logic                 ovf_i,
    input  logic                 mem_ready_i,
    input  logic                 md_done_i,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic                 reg_write_o,
    output logic                 adr_src_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           result_src_o,
    output logic [2:0]           imm_src_o,
    output logic [ALUCTRL_W-1:0] alu_control_o,
    output logic                 md_start_o,
    output logic [2:0]           md_op_o,
    output logic                 illegal_o,
    output logic                 bus_err_o
);
    localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, MULDIV, FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic          take, mem_wait, timeout, is_muldiv;
    logic [3:0]    alu_fn;

    assign is_muldiv = op_i == OP_R && funct7_i == 7'b0000001;
    assign mem_wait  = mem_req_o & ~mem_ready_i;
    assign timeout   = (MEM_TIMEOUT != 0) && mem_wait && wait_q == CW'(MEM_TIMEOUT - 1);
    // the wait counter restarts whenever the FSM moves, so each access gets its own budget
    assign wait_d    = (state_d != state_q) ? '0 :
                       (mem_wait && wait_q != CW'(MEM_TIMEOUT)) ? wait_q + CW'(1) : wait_q;

    always_comb begin
        case (funct3_i)
            3'b000:  alu_fn = (state_q == EXECR && funct7_i[5]) ? 4'd1 : 4'd0;
            3'b001:  alu_fn = 4'd7;
            3'b010:  alu_fn = 4'd5;
            3'b011:  alu_fn = 4'd6;
            3'b100:  alu_fn = 4'd4;
            3'b101:  alu_fn = funct7_i[5] ? 4'd9 : 4'd8;
            3'b110:  alu_fn = 4'd3;
            default: alu_fn = 4'd2;
        endcase
    end

    always_comb begin
        case (funct3_i)
            3'b000:  take = zero_i;
            3'b001:  take = ~zero_i;
            3'b100:  take = neg_i ^ ovf_i;
            3'b101:  take = ~(neg_i ^ ovf_i);
            3'b110:  take = ~carry_i;
            3'b111:  take = carry_i;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            FETCH:    state_d = mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R: begin
                        if (is_muldiv) begin
`ifdef RV_MULDIV_EN
                            state_d = MULDIV;
`else
                            state_d   = FAULT;
                            illegal_d = 1'b1;
`endif
                        end else begin
                            state_d = EXECR;
                        end
                    end
                    OP_I:    state_d = EXECI;
                    OP_BR:   state_d = BRANCH;
                    OP_JAL:  state_d = JAL;
                    OP_JALR: state_d = JALR1;
                    OP_LUI:  state_d = LUI;
                    default: begin
                        state_d   = FAULT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = op_i[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready_i ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready_i ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH: begin
                if (funct3_i[2:1] == 2'b01) begin
                    state_d   = FAULT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            JAL:      state_d = ALUWB;
            JALR1:    state_d = JALR2;
            JALR2:    state_d = FETCH;
            LUI:      state_d = ALUWB;
            MULDIV:   state_d = md_done_i ? ALUWB : MULDIV;
            default:  state_d = FAULT;
        endcase
        if (timeout) begin
            state_d   = FAULT;
            bus_err_d = 1'b1;
        end
    end

`ifdef RV_MULDIV_EN
    logic md_first_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef RV_MULDIV_EN
            md_first_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
`ifdef RV_MULDIV_EN
            md_first_q <= state_d == MULDIV && state_q != MULDIV;
`endif
        end
    end

    // everything is forced low while reset is held, including the sticky flags
    always_comb begin
        mem_req_o     = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        reg_write_o   = 1'b0;
        adr_src_o     = 1'b0;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        result_src_o  = 2'b00;
        imm_src_o     = 3'b000;
        alu_control_o = '0;
        md_start_o    = 1'b0;
        md_op_o       = 3'b000;
        illegal_o     = 1'b0;
        bus_err_o     = 1'b0;
        if (rst_n) begin
            imm_src_o = op_i == OP_STORE ? 3'b001 :
                        op_i == OP_BR    ? 3'b010 :
                        op_i == OP_JAL   ? 3'b011 :
                        (op_i == OP_LUI || op_i == OP_AUIPC) ? 3'b100 : 3'b000;
            illegal_o = illegal_q;
            bus_err_o = bus_err_q;
            case (state_q)
                FETCH: begin
                    mem_req_o    = 1'b1;
                    alu_src_b_o  = 2'b10;
                    result_src_o = 2'b10;
                    ir_write_o   = mem_ready_i;
                    pc_write_o   = mem_ready_i;
                end
                DECODE: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b01;
                end
                MEMADR: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                end
                MEMREAD: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                end
                MEMWB: begin
                    result_src_o = 2'b01;
                    reg_write_o  = 1'b1;
                end
                MEMWRITE: begin
                    mem_req_o   = 1'b1;
                    mem_write_o = 1'b1;
                    adr_src_o   = 1'b1;
                end
                EXECR: begin
                    alu_src_a_o   = 2'b10;
                    alu_control_o = ALUCTRL_W'(alu_fn);
                end
                EXECI: begin
                    alu_src_a_o   = 2'b10;
                    alu_src_b_o   = 2'b01;
                    alu_control_o = ALUCTRL_W'(alu_fn);
                end
                ALUWB: reg_write_o = 1'b1;
                BRANCH: begin
                    alu_src_a_o   = 2'b10;
                    alu_control_o = ALUCTRL_W'(1);
                    pc_write_o    = take;
                end
                JAL: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    pc_write_o  = 1'b1;
                end
                JALR1: begin
                    alu_src_a_o  = 2'b10;
                    alu_src_b_o  = 2'b01;
                    result_src_o = 2'b10;
                    pc_write_o   = 1'b1;
                end
                JALR2: begin
                    alu_src_a_o  = 2'b01;
                    alu_src_b_o  = 2'b10;
                    result_src_o = 2'b10;
                    reg_write_o  = 1'b1;
                end
                LUI: begin
                    alu_src_a_o = 2'b11;
                    alu_src_b_o = 2'b01;
                end
`ifdef RV_MULDIV_EN
                MULDIV: begin
                    md_start_o = md_first_q;
                    md_op_o    = funct3_i;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle output vectors checked through a scoreboard queue.
module tb_multicycle_control_unit;
  typedef struct packed {
    logic       mem_req, mem_write, ir_write, pc_write, reg_write, adr_src;
    logic [1:0] a, b, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       md_start;
    logic [2:0] md_op;
    logic       illegal, bus_err;
  } outs_t;
  typedef struct {
    string name;
    outs_t v;
  } exp_t;
  localparam logic [6:0] R = 7'b0110011, IM = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
  localparam logic [2:0] II = 3'd0, IS = 3'd1, IB = 3'd2, IJ = 3'd3, IU = 3'd4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0, neg = 1'b0, carry = 1'b0, ovf = 1'b0, mem_ready = 1'b0, md_done = 1'b0;
  logic       mem_req, mem_write, ir_write, pc_write, reg_write, adr_src, md_start, illegal, bus_err;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src, md_op;
  logic [3:0] alu_control;
  outs_t      act;
  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0, failures = 0;
  always #5 clk = ~clk;
  multicycle_control_unit #(.MEM_TIMEOUT(4), .ALUCTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .neg_i(neg), .carry_i(carry), .ovf_i(ovf),
    .mem_ready_i(mem_ready), .md_done_i(md_done),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .reg_write_o(reg_write), .adr_src_o(adr_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .result_src_o(result_src),
    .imm_src_o(imm_src), .alu_control_o(alu_control), .md_start_o(md_start),
    .md_op_o(md_op), .illegal_o(illegal), .bus_err_o(bus_err)
  );
  assign act = {mem_req, mem_write, ir_write, pc_write, reg_write, adr_src, alu_src_a, alu_src_b,
                result_src, imm_src, alu_control, md_start, md_op, illegal, bus_err};
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (act !== mon_e.v) begin
        failures++;
        $display("FAIL %s actual=%b required=%b", mon_e.name, act, mon_e.v);
      end
    end
  end
  function automatic outs_t ex(input logic [5:0] s, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] rs, input logic [2:0] imm, input logic [3:0] alu);
    outs_t r = '0;
    {r.mem_req, r.mem_write, r.ir_write, r.pc_write, r.reg_write, r.adr_src} = s;
    r.a = a; r.b = b; r.rs = rs; r.imm = imm; r.alu = alu;
    return r;
  endfunction
  function automatic outs_t flt(input logic [2:0] imm, input logic il, input logic be);
    outs_t r = '0;
    r.imm = imm; r.illegal = il; r.bus_err = be;
    return r;
  endfunction
  function automatic outs_t exmd(input logic st, input logic [2:0] f3);
    outs_t r = '0;
    r.md_start = st; r.md_op = f3;
    return r;
  endfunction
  task automatic chk(input string n, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s actual=%b", n, act);
    end
  endtask
  task automatic cyc(input string n, input logic rdy, input outs_t e);
    exp_t x;
    mem_ready = rdy;
    x.name = n;
    x.v = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic set_i(input logic [6:0] o7, input logic [2:0] f3, input logic [6:0] f7);
    op = o7; funct3 = f3; funct7 = f7;
  endtask
  task automatic rst_cyc();
    rst_n = 1'b0;
    #1;
    chk("reset.all_zero", act === '0);
    cyc("reset", 1'b1, '0);
    rst_n = 1'b1;
  endtask
  task automatic fetch(input string t, input logic [2:0] imm);
    cyc({t, ".fetch"}, 1'b1, ex(6'b101100, 2'b00, 2'b10, 2'b10, imm, 4'd0));
  endtask
  task automatic decode(input string t, input logic [2:0] imm);
    cyc({t, ".decode"}, 1'b1, ex(6'b000000, 2'b01, 2'b01, 2'b00, imm, 4'd0));
  endtask
  task automatic alu(input string t, input logic [6:0] o7, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [3:0] fn, input logic [1:0] b);
    set_i(o7, f3, f7);
    fetch(t, II);
    decode(t, II);
    cyc({t, ".exec"}, 1'b1, ex(6'b000000, 2'b10, b, 2'b00, II, fn));
    cyc({t, ".wb"}, 1'b1, ex(6'b000010, 2'b00, 2'b00, 2'b00, II, 4'd0));
  endtask
  task automatic br(input string t, input logic [2:0] f3, input logic [3:0] fl, input logic tk);
    set_i(BR, f3, 7'd0);
    {zero, neg, carry, ovf} = fl;
    fetch(t, IB);
    decode(t, IB);
    cyc({t, ".br"}, 1'b1, ex({3'b000, tk, 2'b00}, 2'b10, 2'b00, 2'b00, IB, 4'd1));
  endtask
  initial begin
    @(posedge clk);
    #1;
    rst_cyc();
    alu("add", R, 3'b000, 7'b0000000, 4'd0, 2'b00);
    alu("sub", R, 3'b000, 7'b0100000, 4'd1, 2'b00);
    alu("sra", R, 3'b101, 7'b0100000, 4'd9, 2'b00);
    alu("sltu", R, 3'b011, 7'b0000000, 4'd6, 2'b00);
    alu("srai", IM, 3'b101, 7'b0100000, 4'd9, 2'b01);
    alu("addi_f7", IM, 3'b000, 7'b0100000, 4'd0, 2'b01);
    alu("andi", IM, 3'b111, 7'b0000000, 4'd2, 2'b01);
    set_i(LD, 3'b010, 7'd0);
    fetch("lw", II);
    decode("lw", II);
    cyc("lw.adr", 1'b1, ex(6'b000000, 2'b10, 2'b01, 2'b00, II, 4'd0));
    repeat (3) cyc("lw.wait", 1'b0, ex(6'b100001, 2'b00, 2'b00, 2'b00, II, 4'd0));
    cyc("lw.read", 1'b1, ex(6'b100001, 2'b00, 2'b00, 2'b00, II, 4'd0));
    cyc("lw.wb", 1'b1, ex(6'b000010, 2'b00, 2'b00, 2'b01, II, 4'd0));
    set_i(ST, 3'b010, 7'd0);
    repeat (2) cyc("sw.fwait", 1'b0, ex(6'b100000, 2'b00, 2'b10, 2'b10, IS, 4'd0));
    fetch("sw", IS);
    decode("sw", IS);
    cyc("sw.adr", 1'b1, ex(6'b000000, 2'b10, 2'b01, 2'b00, IS, 4'd0));
    repeat (3) cyc("sw.wait", 1'b0, ex(6'b110001, 2'b00, 2'b00, 2'b00, IS, 4'd0));
    cyc("sw.write", 1'b1, ex(6'b110001, 2'b00, 2'b00, 2'b00, IS, 4'd0));
    br("beq", 3'b000, 4'b1000, 1'b1);
    br("bne", 3'b001, 4'b1000, 1'b0);
    br("blt", 3'b100, 4'b0100, 1'b1);
    br("bge", 3'b101, 4'b0101, 1'b1);
    br("bltu", 3'b110, 4'b0000, 1'b1);
    br("bgeu", 3'b111, 4'b0000, 1'b0);
    br("bgeu_c", 3'b111, 4'b0010, 1'b1);
    {zero, neg, carry, ovf} = 4'b0000;
    set_i(JL, 3'b000, 7'd0);
    fetch("jal", IJ);
    decode("jal", IJ);
    cyc("jal.pc", 1'b1, ex(6'b000100, 2'b01, 2'b10, 2'b00, IJ, 4'd0));
    cyc("jal.wb", 1'b1, ex(6'b000010, 2'b00, 2'b00, 2'b00, IJ, 4'd0));
    set_i(JR, 3'b000, 7'd0);
    fetch("jalr", II);
    decode("jalr", II);
    cyc("jalr1", 1'b1, ex(6'b000100, 2'b10, 2'b01, 2'b10, II, 4'd0));
    cyc("jalr2", 1'b1, ex(6'b000010, 2'b01, 2'b10, 2'b10, II, 4'd0));
    set_i(LU, 3'b000, 7'd0);
    fetch("lui", IU);
    decode("lui", IU);
    cyc("lui.exec", 1'b1, ex(6'b000000, 2'b11, 2'b01, 2'b00, IU, 4'd0));
    cyc("lui.wb", 1'b1, ex(6'b000010, 2'b00, 2'b00, 2'b00, IU, 4'd0));
    set_i(R, 3'b000, 7'd0);
    fetch("abort", II);
    decode("abort", II);
    rst_cyc();
    alu("after_rst", R, 3'b100, 7'b0000000, 4'd4, 2'b00);
    set_i(R, 3'b011, 7'b0000001);
    fetch("mul", II);
    decode("mul", II);
`ifdef RV_MULDIV_EN
    md_done = 1'b0;
    cyc("md.start", 1'b1, exmd(1'b1, 3'b011));
    repeat (3) cyc("md.busy", 1'b1, exmd(1'b0, 3'b011));
    md_done = 1'b1;
    cyc("md.done", 1'b1, exmd(1'b0, 3'b011));
    md_done = 1'b0;
    cyc("md.wb", 1'b1, ex(6'b000010, 2'b00, 2'b00, 2'b00, II, 4'd0));
`else
    cyc("md.illegal", 1'b1, flt(II, 1'b1, 1'b0));
    cyc("md.stuck", 1'b1, flt(II, 1'b1, 1'b0));
    rst_cyc();
`endif
    set_i(7'b0000000, 3'b000, 7'd0);
    fetch("op0", II);
    decode("op0", II);
    cyc("op0.illegal", 1'b1, flt(II, 1'b1, 1'b0));
    cyc("op0.hold", 1'b1, flt(II, 1'b1, 1'b0));
    rst_cyc();
    set_i(BR, 3'b010, 7'd0);
    fetch("b010", IB);
    decode("b010", IB);
    cyc("b010.br", 1'b1, ex(6'b000000, 2'b10, 2'b00, 2'b00, IB, 4'd1));
    cyc("b010.illegal", 1'b1, flt(IB, 1'b1, 1'b0));
    cyc("b010.hold", 1'b1, flt(IB, 1'b1, 1'b0));
    rst_cyc();
    set_i(R, 3'b000, 7'd0);
    repeat (4) cyc("to.wait", 1'b0, ex(6'b100000, 2'b00, 2'b10, 2'b10, II, 4'd0));
    cyc("to.bus_err", 1'b0, flt(II, 1'b0, 1'b1));
    chk("to.expired", bus_err === 1'b1 && mem_req === 1'b0);
    cyc("to.hold", 1'b1, flt(II, 1'b0, 1'b1));
    rst_cyc();
    fetch("post_rst", II);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
